pipe_ctrl_gen: RTL
==================

Name: pipe_ctrl_gen

Overview:
Parametrised pipeline controller for the MIPS core. It replaces the single-source load-use stall controller.
- Arbitrates per-stage stall requests into a thermometer stall bus and a one-hot bubble bus.
- Sequences exception flush/redirect through a small FSM with a programmable drain window.
- Keeps saturating stall/flush performance counters and a sticky stall watchdog.
- Sits beside IF/ID/EX/MEM/WB; drives every stage's stall/flush inputs and IF's redirect.

Parameters:
STAGES, 6, width of stall/bubble/stallreq buses; bit 0 = PC register, bit k = k-th pipeline register.
DRAIN_CYCLES, 2, cycles of full freeze after a flush (0 = none).
CNT_W, 16, width of performance counters.
TIMEOUT, 255, consecutive stalled cycles before watchdog fires (>=1).

Ports:
clk  in  1  core clock
rst  in  1  reset; one clock; asynchronous, active-high
stallreq  in  STAGES  bit s=1: stage s requests hold (bit 0 ignored)
excp_valid  in  1  exception committed this cycle
excp_target  in  32  redirect PC for exception
cnt_clr  in  1  synchronous clear of counters and watchdog flag
stall  out  STAGES  bit k=1: hold register k
bubble  out  STAGES  one-hot: register k loads a bubble (NOP)
flush  out  1  clear all pipeline registers this cycle
new_pc_valid  out  1  IF loads new_pc this cycle
new_pc  out  32  redirect target
stall_cycles  out  CNT_W  cycles with stall[0]=1, saturating
flush_cnt  out  CNT_W  flushes taken, saturating
timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async): state=IDLE; all outputs 0; counters 0; internal target reg 0; watchdog count 0.
- FSM states: IDLE, FLUSH, DRAIN.
- IDLE, excp_valid=0:
  - m = highest set bit of stallreq[STAGES-1:1].
  - stall[k]=1 for k<=m, 0 otherwise; combinational, same cycle.
  - bubble[m+1]=1 if m+1<STAGES; none if no request.
- IDLE, excp_valid=1:
  - stall=all ones, bubble=0; stallreq ignored.
  - Latch excp_target; next state FLUSH.
- FLUSH (exactly 1 cycle):
  - flush=1, new_pc_valid=1, new_pc=latched target, stall=0, bubble=0.
  - flush_cnt+=1, saturating.
  - Next state DRAIN if DRAIN_CYCLES>0, else IDLE.
- DRAIN (DRAIN_CYCLES cycles, down-counter):
  - stall=all ones, bubble=0; stallreq and excp_valid ignored.
  - Exit to IDLE when the counter reaches 1.
- excp_valid is ignored in FLUSH and DRAIN; no queuing.
- new_pc outside FLUSH holds the last latched value; new_pc_valid=0.
- stall_cycles: +1 each cycle stall[0]=1, in any state; saturates at all ones.
- Watchdog:
  - Counts consecutive cycles with stall[0]=1; resets to 0 on any cycle with stall[0]=0.
  - When count reaches TIMEOUT, timeout<=1 (registered; visible next cycle) and stays set.
- cnt_clr: next edge zeroes stall_cycles, flush_cnt, watchdog count and timeout.
  - Clear wins over a simultaneous increment.
  - Does not affect the FSM.
- Reset mid-FLUSH/DRAIN: immediate return to IDLE; no flush output after reset release.

Decomposition:
- Shared package/defines.vh: StallBus width default, FSM state encodings, PC width 32.
- Natural sub-module: sat_counter (parametrised width, inc, clr, saturate).
  - Instantiated for stall_cycles and flush_cnt.
  - The watchdog reuses it with a compare against TIMEOUT.

Test Plan:
- Load-use: stallreq=6'b000100 in IDLE -> stall=6'b000111, bubble=6'b001000 same cycle; stall_cycles increments.
- Multiple requests: stallreq=6'b010010 -> stall=6'b011111, bubble=6'b100000. stallreq=6'b100000 -> stall=6'b111111, bubble=0.
- Exception, DRAIN_CYCLES=2, excp_target=32'hBFC00380 at cycle t:
  - t: stall=all ones.
  - t+1: flush=1, new_pc_valid=1, new_pc=32'hBFC00380, flush_cnt=1.
  - t+2, t+3: stall=all ones.
  - t+4: IDLE, stall follows stallreq.
  - A second excp_valid at t+2 is ignored.
- Watchdog, TIMEOUT=4: hold stallreq=6'b000010 for 6 cycles -> timeout=1 after the 4th stalled cycle's edge. Drop the request -> timeout stays 1. cnt_clr -> timeout=0, counters=0.
- Saturation, CNT_W=4: 20 stalled cycles -> stall_cycles=4'hF. cnt_clr together with stall -> 0 next cycle.
- Async reset asserted mid-DRAIN between clock edges -> all outputs 0 immediately; after release, no flush/new_pc_valid and stall mirrors stallreq.

Source files
------------

// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared types and constants for the pipeline controller.
package pipe_ctrl_gen_pkg;

  localparam int unsigned STALL_W_DEF = 6;
  localparam int unsigned PC_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_gen_sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline controller: stall/bubble arbitration, exception flush sequencing,
// saturating performance counters and a sticky stall watchdog.
module pipe_ctrl_gen
  import pipe_ctrl_gen_pkg::*;
#(
  parameter int unsigned STAGES       = STALL_W_DEF,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              excp_valid,
  input  logic [PC_W-1:0]   excp_target,
  input  logic              cnt_clr,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic              flush,
  output logic              new_pc_valid,
  output logic [PC_W-1:0]   new_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              timeout
);

  localparam int unsigned DW   = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  ctrl_state_e       state_q, state_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic              timeout_q, timeout_d;
  logic [STAGES-1:0] arb_stall, arb_bubble;
  logic [WD_W-1:0]   wd_cnt;
  logic              take_excp;

  // Thermometer: every register at or below the highest requesting stage holds.
  always_comb begin
    logic        any;
    int unsigned idx;
    any = 1'b0;
    idx = 0;
    arb_stall = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      idx = STAGES - 1 - i;
      if (idx != 0) begin
        any = any | stallreq[idx];
      end
      arb_stall[idx] = any;
    end
  end

  always_comb begin
    arb_bubble = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      arb_bubble[k] = arb_stall[k-1] & ~arb_stall[k];
    end
  end

  assign take_excp = (state_q == ST_IDLE) && excp_valid;

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    target_d     = target_q;
    stall        = '0;
    bubble       = '0;
    flush        = 1'b0;
    new_pc_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (excp_valid) begin
          stall    = '1;
          target_d = excp_target;
          state_d  = ST_FLUSH;
        end else begin
          stall  = arb_stall;
          bubble = arb_bubble;
        end
      end
      ST_FLUSH: begin
        flush        = 1'b1;
        new_pc_valid = 1'b1;
        if (DRAIN_CYCLES > 0) begin
          drain_d = DW'(DRAIN_CYCLES);
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        stall = '1;
        if (drain_q <= DW'(1)) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The arbitration path is combinational from stallreq, so it must be
    // forced quiet while reset is held to keep every output at zero.
    if (rst) begin
      stall  = '0;
      bubble = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      drain_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      target_q <= target_d;
    end
  end

  assign new_pc = target_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall[0]),
    .clr_i (cnt_clr),
    .cnt_o (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (take_excp),
    .clr_i (cnt_clr),
    .cnt_o (flush_cnt)
  );

  sat_counter #(.W(WD_W)) u_wd_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall[0]),
    .clr_i (cnt_clr | ~stall[0]),
    .cnt_o (wd_cnt)
  );

  // Flag rises on the edge that completes the TIMEOUT-th consecutive stall.
  always_comb begin
    timeout_d = timeout_q;
    if (cnt_clr) begin
      timeout_d = 1'b0;
    end else if (stall[0] && (wd_cnt >= WD_W'(TIMEOUT - 1))) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule
